// File: rtl/fft_pipe_ctrl_if.sv
// Handshake and status bundle between the FFT pipeline sequencer and its environment.
// The master side is the controller; the slave side is the front end / sink.
interface fft_pipe_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 8
);
  localparam int OCC_W = $clog2(NUM_STAGES + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  drain;
  logic                  flush;
  logic                  drain_done;
  logic [OCC_W-1:0]      occupancy;
  logic                  busy;

  modport master (
    input  in_valid, out_ready, drain, flush,
    output in_ready, out_valid, out_tag, stage_en, stage_valid,
           drain_done, occupancy, busy
  );

  modport slave (
    output in_valid, out_ready, drain, flush,
    input  in_ready, out_valid, out_tag, stage_en, stage_valid,
           drain_done, occupancy, busy
  );
endinterface

// File: rtl/fft_pipe_ctrl.sv
// Pipeline sequencer for the 16-point FFT: per-stage enables, valid/tag tracking,
// elastic backpressure, drain mode and synchronous flush. Carries no sample data.
module fft_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  fft_pipe_ctrl_if.master bus
);
  localparam int OCC_W = $clog2(NUM_STAGES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [TAG_W-1:0]      tag_q [NUM_STAGES];
  logic [TAG_W-1:0]      tag_d [NUM_STAGES];
  logic [TAG_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            state_q, state_d;
  logic                  drain_done_q, drain_done_d;
  logic                  drain_hold_q, drain_hold_d;

  logic [NUM_STAGES-1:0] en_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [OCC_W-1:0]      occ_s;

  function automatic logic [OCC_W-1:0] popcount(input logic [NUM_STAGES-1:0] vec);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      n = n + OCC_W'(vec[i]);
    end
    return n;
  endfunction

  // Enable chain: a stage may load whenever it is empty or its content moves on.
  always_comb begin
    logic carry;
    en_s  = '0;
    carry = ~v_q[NUM_STAGES-1] | bus.out_ready;
    en_s[NUM_STAGES-1] = carry;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      carry   = ~v_q[i] | carry;
      en_s[i] = carry;
    end
  end

  // drain_hold keeps the input closed after a drain until drain is released.
  always_comb begin
    in_ready_s = en_s[0] & ~bus.flush & (state_q != ST_DRAIN) & ~(drain_hold_q & bus.drain);
    accept_s   = bus.in_valid & in_ready_s;
    occ_s      = popcount(v_q);
  end

  // Valid bits, frame tags and the tag counter advance with the enable chain.
  always_comb begin
    v_d   = v_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (bus.flush) begin
      v_d   = '0;
      cnt_d = '0;
    end else begin
      if (en_s[0]) begin
        v_d[0]   = accept_s;
        tag_d[0] = cnt_q;
      end else begin
        v_d[0]   = v_q[0];
        tag_d[0] = tag_q[0];
      end
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (en_s[i]) begin
          v_d[i]   = v_q[i-1];
          tag_d[i] = tag_q[i-1];
        end else begin
          v_d[i]   = v_q[i];
          tag_d[i] = tag_q[i];
        end
      end
      if (accept_s) begin
        cnt_d = cnt_q + TAG_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Mode FSM; flush wins over drain, accept and delivery.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    drain_hold_d = drain_hold_q & bus.drain;
    if (bus.flush) begin
      state_d      = ST_IDLE;
      drain_hold_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.drain & ~drain_hold_q) begin
            state_d = ST_DRAIN;
          end else if (accept_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.drain & ~drain_hold_q) begin
            state_d = ST_DRAIN;
          end else if (v_d == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (occ_s == '0) begin
            state_d      = ST_IDLE;
            drain_done_d = 1'b1;
            drain_hold_d = bus.drain;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q          <= '0;
      cnt_q        <= '0;
      state_q      <= ST_IDLE;
      drain_done_q <= 1'b0;
      drain_hold_q <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      v_q          <= v_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      drain_hold_q <= drain_hold_d;
      for (int i = 0; i < NUM_STAGES; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = v_q[NUM_STAGES-1] & ~bus.flush;
  assign bus.out_tag     = tag_q[NUM_STAGES-1];
  assign bus.stage_en    = bus.flush ? {NUM_STAGES{1'b1}} : en_s;
  assign bus.stage_valid = v_q;
  assign bus.drain_done  = drain_done_q;
  assign bus.occupancy   = occ_s;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
